cofactor_sequencer: RTL and testbench

- Multi-round successor to the single-loop cofactor control unit.
- Sequences up to MAX_ROUNDS cofactor operations per start command and routes row streams between the external source, the cofactor unit and the canonical-reduction unit.
- Counts beats in both directions, records the deterministic/randomized outcome of each round, and flags handshake violations.
- Sits between the stabilizer-frame issue logic and the cofactor/canonical datapath pair.

---
 rtl/cofactor_pkg.sv | 46 ++++
 rtl/row_mux3.sv | 36 +++
 rtl/cofactor_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_cofactor_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cofactor_pkg.sv
// Shared types and sizing for the cofactor sequencer: FSM states, row payload, mux source select.
package cofactor_pkg;

   localparam int unsigned NUM_QUBIT  = 3;
   localparam int unsigned NUM_ROWS   = NUM_QUBIT;
   localparam int unsigned MAX_ROUNDS = 4;
   localparam int unsigned LIT_W      = 2 * NUM_QUBIT;
   localparam int unsigned PH_W       = 2 ** NUM_QUBIT;

   // Bits needed to hold the value n itself.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   // Bits needed to index n items.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned RND_W = cnt_w(MAX_ROUNDS);
   localparam int unsigned IDX_W = idx_w(MAX_ROUNDS);
   localparam int unsigned CNT_W = cnt_w(NUM_ROWS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_ALPHA,
      ST_CANON,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_EXT,
      SRC_COF,
      SRC_CAN
   } src_e;

   typedef struct packed {
      logic [LIT_W-1:0] lit;
      logic [PH_W-1:0]  phase;
   } row_t;

   localparam row_t ROW_ZERO = '0;

endpackage

// File: rtl/row_mux3.sv
// Zero-latency row-stream selector: picks one of three sources, or drives an all-zero stream.
module row_mux3
   import cofactor_pkg::*;
(
   input  src_e       sel_i,
   input  logic       ext_valid_i,
   input  row_t       ext_row_i,
   input  logic       cof_valid_i,
   input  row_t       cof_row_i,
   input  logic       can_valid_i,
   input  row_t       can_row_i,
   output logic       valid_c_o,
   output row_t       row_c_o
);

   always_comb begin
      valid_c_o = 1'b0;
      row_c_o   = ROW_ZERO;
      case (sel_i)
         SRC_EXT: begin
            valid_c_o = ext_valid_i;
            row_c_o   = ext_row_i;
         end
         SRC_COF: begin
            valid_c_o = cof_valid_i;
            row_c_o   = cof_row_i;
         end
         SRC_CAN: begin
            valid_c_o = can_valid_i;
            row_c_o   = can_row_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cofactor_sequencer.sv
// Multi-round cofactor control: sequences rounds per start command and routes row streams
// between the external source, the cofactor unit and the canonical-reduction unit.
module cofactor_sequencer
   import cofactor_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [RND_W-1:0]      cfg_rounds,
   input  logic                  abort,
   input  logic                  ext_valid,
   input  logic [LIT_W-1:0]      ext_lit,
   input  logic [PH_W-1:0]       ext_phase,
   input  logic                  valid_P,
   input  logic                  cof_valid_out,
   input  logic [LIT_W-1:0]      cof_lit_out,
   input  logic [PH_W-1:0]       cof_phase_out,
   input  logic                  cof_valid_flag,
   input  logic                  cof_flag_anticommute,
   input  logic                  can_valid_out,
   input  logic [LIT_W-1:0]      can_lit_out,
   input  logic [PH_W-1:0]       can_phase_out,
   output logic                  cof_valid_in,
   output logic [LIT_W-1:0]      cof_lit_in,
   output logic [PH_W-1:0]       cof_phase_in,
   output logic                  cof_valid_P,
   output logic                  can_valid_in,
   output logic [LIT_W-1:0]      can_lit_in,
   output logic [PH_W-1:0]       can_phase_in,
   output logic                  out_valid,
   output logic [LIT_W-1:0]      out_lit,
   output logic [PH_W-1:0]       out_phase,
   output logic                  busy,
   output logic                  done,
   output logic [MAX_ROUNDS-1:0] branch_mask,
   output logic [IDX_W-1:0]      round_idx,
   output logic                  err_proto
);

   state_e                state_q, state_d;
   logic [RND_W-1:0]      rounds_q, rounds_d;
   logic [IDX_W-1:0]      round_idx_q, round_idx_d;
   logic [MAX_ROUNDS-1:0] mask_q, mask_d;
   logic [CNT_W-1:0]      row_cnt_q, row_cnt_d;
   logic                  err_q, err_d;

   logic [RND_W-1:0]      rounds_eff;
   logic                  last_round;
   logic                  round_done;
   logic                  valid_p_c;
   src_e                  cof_sel, can_sel, out_sel;
   row_t                  ext_row, cof_row, can_row;
   row_t                  cof_in_row, can_in_row, out_row;

   assign ext_row = '{lit: ext_lit, phase: ext_phase};
   assign cof_row = '{lit: cof_lit_out, phase: cof_phase_out};
   assign can_row = '{lit: can_lit_out, phase: can_phase_out};

   // Zero requests still run one round; oversize requests saturate at the round capacity.
   always_comb begin
      if (cfg_rounds == '0) begin
         rounds_eff = RND_W'(1);
      end else if (cfg_rounds > RND_W'(MAX_ROUNDS)) begin
         rounds_eff = RND_W'(MAX_ROUNDS);
      end else begin
         rounds_eff = cfg_rounds;
      end
   end

   assign last_round = (RND_W'(round_idx_q) == (rounds_q - RND_W'(1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rounds_q    <= '0;
         round_idx_q <= '0;
         mask_q      <= '0;
         row_cnt_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rounds_q    <= rounds_d;
         round_idx_q <= round_idx_d;
         mask_q      <= mask_d;
         row_cnt_q   <= row_cnt_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rounds_d    = rounds_q;
      round_idx_d = round_idx_q;
      mask_d      = mask_q;
      row_cnt_d   = row_cnt_q;
      err_d       = err_q;
      round_done  = 1'b0;
      valid_p_c   = 1'b0;
      cof_sel     = SRC_NONE;
      can_sel     = SRC_NONE;
      out_sel     = SRC_NONE;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               rounds_d    = rounds_eff;
               round_idx_d = '0;
               mask_d      = '0;
               row_cnt_d   = '0;
               err_d       = 1'b0;
               state_d     = ST_EXT;
            end else if (cof_valid_flag) begin
               err_d = 1'b1;
            end
         end
         ST_EXT: begin
            cof_sel   = SRC_EXT;
            out_sel   = SRC_COF;
            valid_p_c = valid_P;
            if (cof_valid_flag) begin
               if (cof_flag_anticommute) begin
                  mask_d[round_idx_q] = 1'b1;
                  row_cnt_d           = '0;
                  state_d             = ST_ALPHA;
               end else begin
                  round_done = 1'b1;
               end
            end
         end
         ST_ALPHA: begin
            can_sel = SRC_COF;
            if (cof_valid_flag) begin
               err_d = 1'b1;
            end
            // The beat that completes the stream is counted before moving on.
            if (cof_valid_out) begin
               if (row_cnt_q == CNT_W'(NUM_ROWS - 1)) begin
                  row_cnt_d = '0;
                  state_d   = ST_CANON;
               end else begin
                  row_cnt_d = row_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_CANON: begin
            cof_sel   = SRC_CAN;
            valid_p_c = valid_P;
            if (cof_valid_flag) begin
               err_d = 1'b1;
            end
            if (can_valid_out && (row_cnt_q != CNT_W'(NUM_ROWS))) begin
               row_cnt_d = row_cnt_q + CNT_W'(1);
            end
            if (valid_P) begin
               if (row_cnt_q == CNT_W'(NUM_ROWS)) begin
                  round_done = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (cof_valid_flag) begin
               err_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (round_done) begin
         if (last_round) begin
            state_d = ST_DONE;
         end else begin
            round_idx_d = round_idx_q + IDX_W'(1);
            state_d     = ST_EXT;
         end
      end

      // Abort freezes all bookkeeping and only returns to idle.
      if (abort && (state_q != ST_IDLE)) begin
         state_d     = ST_IDLE;
         rounds_d    = rounds_q;
         round_idx_d = round_idx_q;
         mask_d      = mask_q;
         row_cnt_d   = row_cnt_q;
         err_d       = err_q;
      end
   end

   row_mux3 u_cof_in_mux (
      .sel_i       (cof_sel),
      .ext_valid_i (ext_valid),
      .ext_row_i   (ext_row),
      .cof_valid_i (cof_valid_out),
      .cof_row_i   (cof_row),
      .can_valid_i (can_valid_out),
      .can_row_i   (can_row),
      .valid_c_o   (cof_valid_in),
      .row_c_o     (cof_in_row)
   );

   row_mux3 u_can_in_mux (
      .sel_i       (can_sel),
      .ext_valid_i (ext_valid),
      .ext_row_i   (ext_row),
      .cof_valid_i (cof_valid_out),
      .cof_row_i   (cof_row),
      .can_valid_i (can_valid_out),
      .can_row_i   (can_row),
      .valid_c_o   (can_valid_in),
      .row_c_o     (can_in_row)
   );

   row_mux3 u_out_mux (
      .sel_i       (out_sel),
      .ext_valid_i (ext_valid),
      .ext_row_i   (ext_row),
      .cof_valid_i (cof_valid_out),
      .cof_row_i   (cof_row),
      .can_valid_i (can_valid_out),
      .can_row_i   (can_row),
      .valid_c_o   (out_valid),
      .row_c_o     (out_row)
   );

   assign cof_lit_in   = cof_in_row.lit;
   assign cof_phase_in = cof_in_row.phase;
   assign can_lit_in   = can_in_row.lit;
   assign can_phase_in = can_in_row.phase;
   assign out_lit      = out_row.lit;
   assign out_phase    = out_row.phase;

   assign cof_valid_P = valid_p_c;
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign branch_mask = mask_q;
   assign round_idx   = round_idx_q;
   assign err_proto   = err_q;

endmodule

// File: tb/tb_cofactor_sequencer.sv
// Bench for cofactor_sequencer: vector table of commands, corner-case sequences, randomized commands.
module tb_cofactor_sequencer;
   import cofactor_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start, abort, ext_valid, valid_P, cof_valid_out;
   logic                  cof_valid_flag, cof_flag_anticommute, can_valid_out;
   logic [RND_W-1:0]      cfg_rounds;
   logic [LIT_W-1:0]      ext_lit, cof_lit_out, can_lit_out;
   logic [PH_W-1:0]       ext_phase, cof_phase_out, can_phase_out;
   logic                  cof_valid_in, cof_valid_P, can_valid_in, out_valid;
   logic [LIT_W-1:0]      cof_lit_in, can_lit_in, out_lit;
   logic [PH_W-1:0]       cof_phase_in, can_phase_in, out_phase;
   logic                  busy, done, err_proto;
   logic [MAX_ROUNDS-1:0] branch_mask;
   logic [IDX_W-1:0]      round_idx;

   int checks = 0;
   int errors = 0;
   int can_cnt = 0, done_cnt = 0, out_cnt = 0;

   cofactor_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .cfg_rounds(cfg_rounds), .abort(abort),
      .ext_valid(ext_valid), .ext_lit(ext_lit), .ext_phase(ext_phase), .valid_P(valid_P),
      .cof_valid_out(cof_valid_out), .cof_lit_out(cof_lit_out), .cof_phase_out(cof_phase_out),
      .cof_valid_flag(cof_valid_flag), .cof_flag_anticommute(cof_flag_anticommute),
      .can_valid_out(can_valid_out), .can_lit_out(can_lit_out), .can_phase_out(can_phase_out),
      .cof_valid_in(cof_valid_in), .cof_lit_in(cof_lit_in), .cof_phase_in(cof_phase_in),
      .cof_valid_P(cof_valid_P), .can_valid_in(can_valid_in), .can_lit_in(can_lit_in),
      .can_phase_in(can_phase_in), .out_valid(out_valid), .out_lit(out_lit), .out_phase(out_phase),
      .busy(busy), .done(done), .branch_mask(branch_mask), .round_idx(round_idx),
      .err_proto(err_proto)
   );

   always #5 clk = ~clk;

   // Stream activity counters, sampled late in each cycle once inputs have settled.
   always begin
      @(negedge clk);
      #4;
      if (can_valid_in) can_cnt++;
      if (done) done_cnt++;
      if (out_valid) out_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic clr();
      start = 1'b0; abort = 1'b0; ext_valid = 1'b0; valid_P = 1'b0; cof_valid_out = 1'b0;
      cof_valid_flag = 1'b0; cof_flag_anticommute = 1'b0; can_valid_out = 1'b0;
      ext_lit = '0; ext_phase = '0; cof_lit_out = '0; cof_phase_out = '0;
      can_lit_out = '0; can_phase_out = '0;
   endtask

   task automatic step();
      @(negedge clk);
      clr();
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) step();
   endtask

   // Reference rule for the number of rounds a command runs.
   function automatic int eff_rounds(input int cfg);
      if (cfg == 0) return 1;
      if (cfg > int'(MAX_ROUNDS)) return int'(MAX_ROUNDS);
      return cfg;
   endfunction

   task automatic start_cmd(input int cfg);
      step();
      start = 1'b1;
      cfg_rounds = RND_W'(cfg);
      #2 chk("idle_busy", busy, 0);
      step();
      #2;
      chk("cmd_busy", busy, 1);
      chk("cmd_err_clear", err_proto, 0);
      chk("cmd_mask_clear", branch_mask, 0);
      chk("cmd_round0", round_idx, 0);
   endtask

   task automatic ext_beats();
      for (int b = 0; b < int'(NUM_ROWS); b++) begin
         gap();
         step();
         ext_valid = 1'b1; ext_lit = LIT_W'($urandom); ext_phase = PH_W'($urandom);
         cof_valid_out = 1'b1; cof_lit_out = LIT_W'($urandom); cof_phase_out = PH_W'($urandom);
         valid_P = 1'($urandom);
         #2;
         chk("ext_cof_valid_in", cof_valid_in, 1);
         chk("ext_cof_lit_in", cof_lit_in, ext_lit);
         chk("ext_cof_phase_in", cof_phase_in, ext_phase);
         chk("ext_out_valid", out_valid, 1);
         chk("ext_out_lit", out_lit, cof_lit_out);
         chk("ext_out_phase", out_phase, cof_phase_out);
         chk("ext_can_valid_in", can_valid_in, 0);
         chk("ext_valid_P", cof_valid_P, valid_P);
      end
   endtask

   task automatic send_flag(input logic anti);
      step();
      cof_valid_flag = 1'b1;
      cof_flag_anticommute = anti;
      #2;
   endtask

   task automatic alpha_beats(input int n);
      for (int b = 0; b < n; b++) begin
         gap();
         step();
         cof_valid_out = 1'b1; cof_lit_out = LIT_W'($urandom); cof_phase_out = PH_W'($urandom);
         valid_P = 1'b1;
         #2;
         chk("alpha_can_valid_in", can_valid_in, 1);
         chk("alpha_can_lit_in", can_lit_in, cof_lit_out);
         chk("alpha_can_phase_in", can_phase_in, cof_phase_out);
         chk("alpha_out_valid", out_valid, 0);
         chk("alpha_out_lit", out_lit, 0);
         chk("alpha_cof_valid_in", cof_valid_in, 0);
         chk("alpha_valid_P_gated", cof_valid_P, 0);
      end
   endtask

   task automatic canon_beats(input int n);
      for (int b = 0; b < n; b++) begin
         gap();
         step();
         can_valid_out = 1'b1; can_lit_out = LIT_W'($urandom); can_phase_out = PH_W'($urandom);
         #2;
         chk("canon_cof_valid_in", cof_valid_in, 1);
         chk("canon_cof_lit_in", cof_lit_in, can_lit_out);
         chk("canon_cof_phase_in", cof_phase_in, can_phase_out);
         chk("canon_can_valid_in", can_valid_in, 0);
         chk("canon_out_valid", out_valid, 0);
      end
   endtask

   task automatic give_p();
      step();
      valid_P = 1'b1;
      #2 chk("canon_valid_P", cof_valid_P, 1);
   endtask

   task automatic expect_done(input logic [MAX_ROUNDS-1:0] mask);
      step();
      #2;
      chk("done_pulse", done, 1);
      chk("done_mask", branch_mask, mask);
      step();
      #2;
      chk("done_one_cycle", done, 0);
      chk("done_idle", busy, 0);
      chk("mask_hold", branch_mask, mask);
   endtask

   task automatic run_cmd(input int cfg, input logic [MAX_ROUNDS-1:0] outc,
                          input logic [MAX_ROUNDS-1:0] exp_mask);
      int n, k, c0, d0, o0;
      n = eff_rounds(cfg);
      k = 0;
      for (int r = 0; r < n; r++) k += int'(outc[r]);
      c0 = can_cnt; d0 = done_cnt; o0 = out_cnt;
      start_cmd(cfg);
      for (int r = 0; r < n; r++) begin
         step();
         #2 chk("round_idx", round_idx, r);
         ext_beats();
         send_flag(outc[r]);
         if (outc[r]) begin
            alpha_beats(int'(NUM_ROWS));
            canon_beats(int'(NUM_ROWS));
            give_p();
         end
      end
      expect_done(exp_mask);
      chk("can_in_beats", can_cnt - c0, k * int'(NUM_ROWS));
      chk("done_count", done_cnt - d0, 1);
      chk("out_beats", out_cnt - o0, n * int'(NUM_ROWS));
      chk("no_proto_err", err_proto, 0);
   endtask

   typedef struct {
      int                    cfg;
      logic [MAX_ROUNDS-1:0] outc;
      logic [MAX_ROUNDS-1:0] exp_mask;
   } vec_t;

   vec_t tbl[7];

   initial begin
      tbl[0] = '{cfg: 1, outc: 4'b0000, exp_mask: 4'b0000};
      tbl[1] = '{cfg: 1, outc: 4'b0001, exp_mask: 4'b0001};
      tbl[2] = '{cfg: 3, outc: 4'b0010, exp_mask: 4'b0010};
      tbl[3] = '{cfg: 0, outc: 4'b0001, exp_mask: 4'b0001};
      tbl[4] = '{cfg: 7, outc: 4'b1111, exp_mask: 4'b1111};
      tbl[5] = '{cfg: 4, outc: 4'b1010, exp_mask: 4'b1010};
      tbl[6] = '{cfg: 2, outc: 4'b0110, exp_mask: 4'b0010};

      clr();
      cfg_rounds = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mask", branch_mask, 0);
      chk("rst_round", round_idx, 0);
      chk("rst_err", err_proto, 0);
      chk("rst_cof_valid_in", cof_valid_in, 0);
      chk("rst_out_valid", out_valid, 0);
      rst = 1'b0;

      foreach (tbl[i]) run_cmd(tbl[i].cfg, tbl[i].outc, tbl[i].exp_mask);

      // Early valid_P in CANON flags an error and holds the state.
      start_cmd(1);
      ext_beats();
      send_flag(1'b1);
      alpha_beats(int'(NUM_ROWS));
      canon_beats(int'(NUM_ROWS) - 1);
      give_p();
      step();
      #2;
      chk("early_p_err", err_proto, 1);
      chk("early_p_busy", busy, 1);
      canon_beats(1);
      give_p();
      expect_done(4'b0001);
      chk("early_p_err_sticky", err_proto, 1);

      // Abort in ALPHA after one beat, with a stray flag first.
      start_cmd(2);
      ext_beats();
      send_flag(1'b1);
      alpha_beats(1);
      step();
      cof_valid_flag = 1'b1;
      #2;
      step();
      abort = 1'b1;
      #2 chk("stray_flag_err", err_proto, 1);
      step();
      valid_P = 1'b1; cof_valid_out = 1'b1; can_valid_out = 1'b1; ext_valid = 1'b1;
      #2;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_valid_P", cof_valid_P, 0);
      chk("abort_can_valid_in", can_valid_in, 0);
      chk("abort_cof_valid_in", cof_valid_in, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_mask_kept", branch_mask, 4'b0001);
      chk("abort_err_kept", err_proto, 1);
      run_cmd(1, 4'b0000, 4'b0000);

      // Asynchronous reset in the middle of CANON.
      start_cmd(1);
      ext_beats();
      send_flag(1'b1);
      alpha_beats(int'(NUM_ROWS));
      canon_beats(1);
      step();
      can_valid_out = 1'b1; can_lit_out = LIT_W'(6'h2a);
      #2 chk("pre_rst_cof_valid_in", cof_valid_in, 1);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_cof_valid_in", cof_valid_in, 0);
      chk("async_rst_cof_lit_in", cof_lit_in, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_mask", branch_mask, 0);
      step();
      rst = 1'b0;
      step();
      #2;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_round", round_idx, 0);
      run_cmd(0, 4'b0000, 4'b0000);

      // Randomized commands against the round/mask reference rules.
      for (int t = 0; t < 30; t++) begin
         int                    cfg, n;
         logic [MAX_ROUNDS-1:0] outc, m;
         cfg  = int'($urandom_range(0, 7));
         outc = MAX_ROUNDS'($urandom);
         n    = eff_rounds(cfg);
         m    = '0;
         for (int r = 0; r < n; r++) m[r] = outc[r];
         run_cmd(cfg, outc, m);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
